// File: rtl/cb_cfg_pkg.sv
// Shared types and helpers for the connection-block configuration loader.
package cb_cfg_pkg;

   // Loader FSM states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      COMMIT = 2'd2
   } cfg_state_t;

   // Width of c for a default connection_block tile: 24 output-mux bits + 20 input-mux bits
   localparam int CB_CFG_NBITS = 44;

   // Number of W-bit words needed to carry nbits of configuration
   function automatic int cfg_nwords(input int nbits, input int w);
      return (nbits + w - 1) / w;
   endfunction

endpackage

// File: rtl/cfg_word_shadow.sv
// Shadow register for a configuration bitstream: indexed word writes, clear,
// and a check that the padding bits of the incoming word are zero.
module cfg_word_shadow
   import cb_cfg_pkg::*;
#(
   parameter int NBITS = CB_CFG_NBITS,
   parameter int W     = 8
) (
   input  logic                 clk,
   input  logic                 i_rst,
   input  logic                 i_clr,
   input  logic                 i_wr_en,
   input  logic [((cfg_nwords(NBITS, W) > 1) ? $clog2(cfg_nwords(NBITS, W)) : 1)-1:0] i_wr_idx,
   input  logic [W-1:0]         i_wr_data,
   output logic [NBITS-1:0]     o_shadow,
   output logic                 o_pad_ok
);

   localparam int NWORDS = cfg_nwords(NBITS, W);
   localparam int IW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam int PADW   = NWORDS * W - NBITS;

   logic [NBITS-1:0] w_flat;

   // One register per word; the last word only keeps its meaningful low bits
   for (genvar gi = 0; gi < NWORDS; gi++) begin : g_word
      localparam int LO = gi * W;
      localparam int WW = (gi == NWORDS - 1) ? (NBITS - LO) : W;

      logic [WW-1:0] r_word;

      // Clear on reset or load (re)start, otherwise capture the addressed word
      always_ff @(posedge clk) begin
         if (i_rst || i_clr) begin
            r_word <= '0;
         end else if (i_wr_en && (i_wr_idx == IW'(gi))) begin
            r_word <= i_wr_data[WW-1:0];
         end
      end

      assign w_flat[LO +: WW] = r_word;
   end

   assign o_shadow = w_flat;

   // Padding bits are the top PADW bits of whichever word is being written;
   // the caller only acts on this for the final word.
   if (PADW > 0) begin : g_pad
      assign o_pad_ok = (i_wr_data[W-1 -: PADW] == '0);
   end else begin : g_nopad
      assign o_pad_ok = 1'b1;
   end

endmodule

// File: rtl/cb_config_loader.sv
// Configuration loader for one connection_block tile: assembles a word stream
// in a shadow register and commits it to c/cset atomically once complete.
module cb_config_loader
   import cb_cfg_pkg::*;
#(
   parameter int NBITS = CB_CFG_NBITS,
   parameter int W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_start,
   input  logic [W-1:0]     din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic [NBITS-1:0] c,
   output logic             cset,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam int NWORDS = cfg_nwords(NBITS, W);
   localparam int CW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;

   cfg_state_t       r_state;
   cfg_state_t       w_state_next;
   logic [CW-1:0]    r_count;
   logic [NBITS-1:0] r_c;
   logic             r_cset;
   logic             r_done;
   logic             r_err;

   logic             w_clr;
   logic             w_wr;
   logic             w_last;
   logic             w_pad_ok;
   logic             w_pad_fail;
   logic [NBITS-1:0] w_shadow;

   cfg_word_shadow #(
      .NBITS (NBITS),
      .W     (W)
   ) u_shadow (
      .clk       (clk),
      .i_rst     (rst),
      .i_clr     (w_clr),
      .i_wr_en   (w_wr),
      .i_wr_idx  (r_count),
      .i_wr_data (din),
      .o_shadow  (w_shadow),
      .o_pad_ok  (w_pad_ok)
   );

   assign w_last = (r_count == CW'(NWORDS - 1));

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next state and datapath strobes; a restart in LOAD beats a same-cycle transfer
   always_comb begin
      w_state_next = r_state;
      w_clr        = 1'b0;
      w_wr         = 1'b0;
      w_pad_fail   = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (load_start) begin
               w_state_next = LOAD;
               w_clr        = 1'b1;
            end
         end
         LOAD: begin
            if (load_start) begin
               w_clr = 1'b1;
            end else if (din_valid) begin
               w_wr = 1'b1;
               if (w_last) begin
                  if (w_pad_ok) begin
                     w_state_next = COMMIT;
                  end else begin
                     w_state_next = IDLE;
                     w_pad_fail   = 1'b1;
                  end
               end
            end
         end
         COMMIT: begin
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // Word counter, committed configuration and status flags
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
         r_c     <= '0;
         r_cset  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         if (w_clr) begin
            r_count <= '0;
         end else if (w_wr) begin
            r_count <= r_count + 1'b1;
         end
         if ((r_state == IDLE) && load_start) begin
            r_cset <= 1'b0;
            r_err  <= 1'b0;
         end
         if (w_pad_fail) begin
            r_err <= 1'b1;
         end
         if (r_state == COMMIT) begin
            r_c    <= w_shadow;
            r_cset <= 1'b1;
         end
         r_done <= (r_state == COMMIT);
      end
   end

   assign din_ready = (r_state == LOAD);
   assign busy      = (r_state != IDLE);
   assign c         = r_c;
   assign cset      = r_cset;
   assign done      = r_done;
   assign err       = r_err;

endmodule

// File: tb/tb_cb_config_loader.sv
// Scoreboard bench for cb_config_loader: stimulus pushes expected outcomes,
// a negedge monitor pops them on done / err and checks c and cset.
module tb_cb_config_loader;

   localparam int NBITS = 44;
   localparam int W     = 8;
   localparam int NW    = 6;

   logic             clk = 1'b0;
   logic             rst;
   logic             load_start;
   logic [W-1:0]     din;
   logic             din_valid;
   logic             din_ready;
   logic [NBITS-1:0] c;
   logic             cset;
   logic             busy;
   logic             done;
   logic             err;

   always #5 clk = ~clk;

   cb_config_loader #(.NBITS(NBITS), .W(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_start (load_start),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .c          (c),
      .cset       (cset),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   typedef struct {
      bit               is_err;
      logic [NBITS-1:0] c;
      int               lat;
   } exp_t;

   exp_t             exp_q[$];
   int               n_checks = 0;
   int               n_fail   = 0;
   int               cyc      = 0;
   int               start_cyc = 0;
   logic [NBITS-1:0] model_committed = '0;
   logic [W-1:0]     wds [NW];
   bit               mon_en   = 1'b0;
   bit               rst_edge = 1'b0;
   logic             err_prev = 1'b0;
   logic [NBITS-1:0] c_prev   = '0;

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_edge <= rst;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Reference: the stream is a little-endian base-256 number; the top 4 bits
   // of the 48 carried bits are padding and must be zero.
   function automatic logic [NBITS-1:0] model_c();
      logic [63:0] acc = 0;
      for (int k = 0; k < NW; k++) acc = acc + (64'(wds[k]) << (8 * k));
      return acc[NBITS-1:0];
   endfunction

   function automatic bit model_bad();
      return wds[NW-1] > 8'h0F;
   endfunction

   // Monitor: every cycle, invariants; on done / err rise, pop and compare
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         if (done) begin
            if (exp_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_done: got done=1 required no commit (cycle %0d)", cyc);
            end else begin
               e = exp_q.pop_front();
               check("done_kind_is_err", 64'(e.is_err), 64'(0));
               check("commit_c", 64'(c), 64'(e.c));
               check("commit_cset", 64'(cset), 64'(1));
               if (e.lat > 0) check("done_latency", 64'(cyc - start_cyc), 64'(e.lat));
            end
         end
         if (err && !err_prev) begin
            if (exp_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_err: got err=1 required no error (cycle %0d)", cyc);
            end else begin
               e = exp_q.pop_front();
               check("err_kind_is_err", 64'(e.is_err), 64'(1));
               check("err_c_unchanged", 64'(c), 64'(e.c));
               check("err_cset", 64'(cset), 64'(0));
               check("err_busy", 64'(busy), 64'(0));
               check("err_done", 64'(done), 64'(0));
            end
         end
         if (busy) check("cset_low_while_busy", 64'(cset), 64'(0));
         if (!done && !rst_edge) check("c_stable", 64'(c), 64'(c_prev));
      end
      err_prev = err;
      c_prev   = c;
   end

   task automatic pulse_start();
      load_start = 1'b1;
      start_cyc  = cyc;
      @(negedge clk);
      load_start = 1'b0;
      check("start_ready", 64'(din_ready), 64'(1));
      check("start_err_clear", 64'(err), 64'(0));
      check("start_cset_clear", 64'(cset), 64'(0));
   endtask

   task automatic send_word(input logic [W-1:0] w, input int stall);
      int guard = 0;
      repeat (stall) @(negedge clk);
      din       = w;
      din_valid = 1'b1;
      while (!din_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) check("ready_timeout", 64'(0), 64'(1));
      @(negedge clk);
      din_valid = 1'b0;
      din       = W'($urandom);
   endtask

   task automatic push_expect(input bit chk_lat);
      exp_t e;
      e.is_err = model_bad();
      e.c      = e.is_err ? model_committed : model_c();
      e.lat    = chk_lat ? 8 : 0;
      if (!e.is_err) model_committed = e.c;
      exp_q.push_back(e);
   endtask

   task automatic send_all(input int smin, input int smax);
      for (int k = 0; k < NW; k++) send_word(wds[k], $urandom_range(smax, smin));
   endtask

   task automatic wait_idle();
      int guard = 0;
      while (busy && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 40) check("idle_timeout", 64'(0), 64'(1));
      @(negedge clk);
   endtask

   task automatic set_words(input logic [47:0] v);
      for (int k = 0; k < NW; k++) wds[k] = v[8*k +: 8];
   endtask

   initial begin
      rst = 1'b1; load_start = 1'b0; din_valid = 1'b1; din = 8'h5A;
      repeat (2) @(negedge clk);
      check("rst_c", 64'(c), 64'(0));
      check("rst_cset", 64'(cset), 64'(0));
      check("rst_ready", 64'(din_ready), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_err", 64'(err), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      rst = 1'b0; din_valid = 1'b0;
      @(negedge clk);
      mon_en = 1'b1;

      // Basic back-to-back load with latency check
      set_words(48'h0A8967452301);
      push_expect(1'b1);
      pulse_start();
      send_all(0, 0);
      wait_idle();
      check("basic_c_const", 64'(c), 64'(44'h0A8967452301));

      // Same data with 3-cycle stalls
      push_expect(1'b0);
      pulse_start();
      send_all(3, 3);
      wait_idle();
      check("stall_c_const", 64'(c), 64'(44'h0A8967452301));

      // Padding error, then a good load clears err
      set_words(48'hF0_33_22_11_00_FF);
      push_expect(1'b0);
      pulse_start();
      send_all(0, 1);
      wait_idle();
      check("pad_err_flag", 64'(err), 64'(1));
      set_words(48'h05_44_33_22_11_C3);
      push_expect(1'b0);
      pulse_start();
      send_all(0, 0);
      wait_idle();

      // Restart: 3 words, then restart with a colliding word, then fresh data
      pulse_start();
      for (int k = 0; k < 3; k++) send_word(8'hE0 + 8'(k), 0);
      load_start = 1'b1; din_valid = 1'b1; din = 8'hAA;
      @(negedge clk);
      load_start = 1'b0; din_valid = 1'b0;
      set_words(48'h0B_7D_6C_5B_4A_39);
      push_expect(1'b0);
      send_all(0, 0);
      wait_idle();

      // Mid-load reset, then a full load
      pulse_start();
      for (int k = 0; k < 4; k++) send_word(8'h10 + 8'(k), 0);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_c", 64'(c), 64'(0));
      check("midrst_cset", 64'(cset), 64'(0));
      check("midrst_ready", 64'(din_ready), 64'(0));
      check("midrst_busy", 64'(busy), 64'(0));
      check("midrst_done", 64'(done), 64'(0));
      check("midrst_err", 64'(err), 64'(0));
      rst = 1'b0;
      model_committed = '0;
      @(negedge clk);
      set_words(48'h0F_EE_DD_CC_BB_AA);
      push_expect(1'b1);
      pulse_start();
      send_all(0, 0);
      wait_idle();

      // Randomized loads, roughly a quarter with bad padding
      for (int n = 0; n < 20; n++) begin
         for (int k = 0; k < NW - 1; k++) wds[k] = 8'($urandom_range(0, 255));
         wds[NW-1] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(16, 255))
                                                 : 8'($urandom_range(0, 15));
         push_expect(1'b0);
         pulse_start();
         send_all(0, 2);
         wait_idle();
      end

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
